// File: rtl/tmr_pipe_reg_pkg.sv
// tmr_pkg: shared majority helper, injection constants and port width helpers
package tmr_pkg;
  localparam logic [1:0] INJ_NONE = 2'd3;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction
  function automatic int stage_w(input int stages);
    return $clog2(stages) + 1;
  endfunction
  function automatic int bit_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/tmr_pipe_reg_if.sv
// tmr_pipe_reg_if: datapath, error-report and fault-injection signals of the TMR register
interface tmr_pipe_reg_if
  import tmr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
);
  logic                        en_i;
  logic                        valid_i;
  logic [WIDTH-1:0]            data_i;
  logic                        valid_o;
  logic [WIDTH-1:0]            data_o;
  logic                        err_o;
  logic                        err_sticky_o;
  logic [CNT_W-1:0]            err_cnt_o;
  logic                        err_clr_i;
  logic                        inj_i;
  logic [stage_w(STAGES)-1:0]  inj_stage_i;
  logic [1:0]                  inj_copy_i;
  logic [bit_w(WIDTH)-1:0]     inj_bit_i;
  modport master (
    output en_i, valid_i, data_i, err_clr_i, inj_i, inj_stage_i, inj_copy_i, inj_bit_i,
    input  valid_o, data_o, err_o, err_sticky_o, err_cnt_o
  );
  modport slave (
    input  en_i, valid_i, data_i, err_clr_i, inj_i, inj_stage_i, inj_copy_i, inj_bit_i,
    output valid_o, data_o, err_o, err_sticky_o, err_cnt_o
  );
endinterface

// File: rtl/tmr_pipe_reg_voter.sv
// tmr_voter: bitwise 2-of-3 majority with a flag for any copy disagreeing with the result
module tmr_voter
  import tmr_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic         mm
);
  // per-bit majority
  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) y[i] = maj3(a[i], b[i], c[i]);
  end
  assign mm = (a != y) || (b != y) || (c != y);
endmodule

// File: rtl/tmr_pipe_reg.sv
// tmr_pipe_reg: triple-redundant pipeline register with voting, scrubbing, error tracking and fault injection
module tmr_pipe_reg
  import tmr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  tmr_pipe_reg_if.slave bus
);
  localparam int D = WIDTH + 1;
  logic [D-1:0]      cp   [STAGES][3];
  logic [D-1:0]      vote [STAGES];
  logic [D-1:0]      nxt  [STAGES];
  logic [STAGES-1:0] mm;
  logic [D-1:0]      mask;
  logic              inj_ok;
  logic              err_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  cnt_q;
  wire               any_mm = |mm;
  // copies reload from a voted value so one upset never survives an edge
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    tmr_voter #(.W(D)) u_voter (
      .a(cp[s][0]), .b(cp[s][1]), .c(cp[s][2]), .y(vote[s]), .mm(mm[s])
    );
    if (s == 0) begin : g_first
      assign nxt[s] = bus.en_i ? {bus.valid_i, bus.data_i} : vote[s];
    end else begin : g_rest
      assign nxt[s] = bus.en_i ? vote[s-1] : vote[s];
    end
  end
  assign inj_ok = bus.inj_i && bus.inj_copy_i != INJ_NONE
               && int'(bus.inj_stage_i) < STAGES && int'(bus.inj_bit_i) <= WIDTH;
  assign mask = D'(1) << bus.inj_bit_i;
  // copy array: advance or scrub, with the injected flip applied on top
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++)
      for (int k = 0; k < 3; k++)
        cp[s][k] <= rst ? '0 : nxt[s] ^ ((inj_ok && int'(bus.inj_stage_i) == s
                                          && int'(bus.inj_copy_i) == k) ? mask : '0);
  end
  // error pulse, sticky flag and saturating counter; clear beats a same-cycle mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      err_q    <= any_mm;
      sticky_q <= !bus.err_clr_i && (sticky_q || any_mm);
      cnt_q    <= bus.err_clr_i ? '0 : (any_mm && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  assign {bus.valid_o, bus.data_o} = vote[STAGES-1];
  assign bus.err_o        = err_q;
  assign bus.err_sticky_o = sticky_q;
  assign bus.err_cnt_o    = cnt_q;
endmodule

// File: tb/tb_tmr_pipe_reg.sv
// tb_tmr_pipe_reg: directed vector checks of the TMR pipeline register and its voter
module tb_tmr_pipe_reg;
  typedef struct {
    logic       en, v;
    logic [7:0] d;
    logic       inj;
    logic [1:0] st, cp;
    logic [3:0] b;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       ee, es;
    logic [1:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  logic [8:0] va, vb, vc, vy;
  logic vmm;

  always #5 clk = ~clk;

  tmr_pipe_reg_if #(.WIDTH(8), .STAGES(2), .CNT_W(2)) bus ();
  tmr_pipe_reg #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  tmr_voter #(.W(9)) u_v (.a(va), .b(vb), .c(vc), .y(vy), .mm(vmm));

  function automatic vec_t mk(input logic en, input logic v, input logic [7:0] d,
                              input logic inj, input logic [1:0] st, input logic [1:0] cp,
                              input logic [3:0] b, input logic clr, input logic ev,
                              input logic [7:0] ed, input logic ee, input logic es,
                              input logic [1:0] ec);
    vec_t t;
    t.en = en; t.v = v; t.d = d; t.inj = inj; t.st = st; t.cp = cp; t.b = b; t.clr = clr;
    t.ev = ev; t.ed = ed; t.ee = ee; t.es = es; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input logic r, input int idx);
    @(negedge clk);
    rst = r;
    bus.en_i = t.en; bus.valid_i = t.v; bus.data_i = t.d;
    bus.inj_i = t.inj; bus.inj_stage_i = t.st; bus.inj_copy_i = t.cp; bus.inj_bit_i = t.b;
    bus.err_clr_i = t.clr;
    @(posedge clk);
    #1;
    chk("valid_o", idx, 32'(bus.valid_o), 32'(t.ev));
    chk("data_o", idx, 32'(bus.data_o), 32'(t.ed));
    chk("err_o", idx, 32'(bus.err_o), 32'(t.ee));
    chk("err_sticky_o", idx, 32'(bus.err_sticky_o), 32'(t.es));
    chk("err_cnt_o", idx, 32'(bus.err_cnt_o), 32'(t.ec));
  endtask

  initial begin
    bus.en_i = 0; bus.valid_i = 0; bus.data_i = 0; bus.inj_i = 0;
    bus.inj_stage_i = 0; bus.inj_copy_i = 0; bus.inj_bit_i = 0; bus.err_clr_i = 0;
    va = 0; vb = 0; vc = 0;
    //              en v  d      inj st cp b  clr  ev ed     ee es ec
    // basic latency
    tbl.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'hA5, 0, 0, 0));
    // stall with stage-0 upset, scrubbed
    tbl.push_back(mk(1, 1, 8'h3C, 0, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 2, 0,   1, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h3C, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h3C, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1,   1, 8'h3C, 0, 0, 0));
    // streaming with stage-1 upset on the second word
    tbl.push_back(mk(1, 1, 8'h01, 0, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h02, 1, 1, 0, 7, 0,   1, 8'h01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h03, 0, 0, 0, 0, 0,   1, 8'h02, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1,   1, 8'h03, 0, 0, 0));
    // invalid targets: copy 3, stage 2, bit 9
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 3, 0, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 0, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 9, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 0, 0, 0));
    // valid bit (bit index WIDTH) is a legal target
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1,   1, 8'h03, 0, 0, 0));
    // counter saturation over repeated upsets, then clear against a live mismatch
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 1, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 1, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h03, 1, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1,   1, 8'h03, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h03, 0, 1, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, 32'(bus.valid_o), 0);
    chk("rst_data", 0, 32'(bus.data_o), 0);
    chk("rst_err", 0, 32'(bus.err_o), 0);
    chk("rst_sticky", 0, 32'(bus.err_sticky_o), 0);
    chk("rst_cnt", 0, 32'(bus.err_cnt_o), 0);

    foreach (tbl[i]) apply(tbl[i], 1'b0, i);

    // reset mid-stream with an injection pending: everything clears, no upset remains
    apply(mk(1, 1, 8'h55, 0, 0, 0, 0, 0,   0, 8'h00, 0, 1, 1), 1'b0, 100);
    apply(mk(1, 1, 8'hAA, 1, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0), 1'b1, 101);
    apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0), 1'b0, 102);
    apply(mk(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0), 1'b0, 103);

    // voter: clean, single upset, double upset on one bit, three-way disagreement
    va = 9'h1A5; vb = 9'h1A5; vc = 9'h1A5; #1;
    chk("vote_y", 0, 32'(vy), 32'h1A5); chk("vote_mm", 0, 32'(vmm), 0);
    va = 9'h1A5; vb = 9'h025; vc = 9'h1A5; #1;
    chk("vote_y", 1, 32'(vy), 32'h1A5); chk("vote_mm", 1, 32'(vmm), 1);
    va = 9'h0A4; vb = 9'h0A5; vc = 9'h0A4; #1;
    chk("vote_y", 2, 32'(vy), 32'h0A4); chk("vote_mm", 2, 32'(vmm), 1);
    va = 9'h0F0; vb = 9'h0CC; vc = 9'h0AA; #1;
    chk("vote_y", 3, 32'(vy), 32'h0E8); chk("vote_mm", 3, 32'(vmm), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
